debounce_scheduler: RTL

//  Debounces N_BTN push-button inputs by sharing one 8 ms countTimer between them.

---
 rtl/debounce_scheduler.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/debounce_scheduler.sv
// Debounces N_BTN buttons by time-sharing one external count timer.
// Each button is synchronised, and a button whose synchronised level differs from its clean
// level requests the timer. Requests are granted round-robin. A new clean level is committed
// only if the input held for the full timer period.
module debounce_scheduler #(
  parameter int unsigned N_BTN       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btnIn,
  input  logic             timerOut,
  output logic             timerControl,
  output logic [N_BTN-1:0] btnClean,
  output logic [N_BTN-1:0] btnPress,
  output logic [N_BTN-1:0] btnRelease,
  output logic             busy,
  output logic [IDX_W-1:0] activeIdx
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StTiming = 2'd1;
  localparam logic [1:0] StDone   = 2'd2;

  logic [N_BTN-1:0] sync_q [SYNC_STAGES];
  logic [N_BTN-1:0] sync;
  logic [N_BTN-1:0] pending;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] active_q, active_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [N_BTN-1:0] clean_q, clean_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;

  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] next_idx;
  logic             act_pending;
  logic             act_sync;
  int unsigned      rr_int;
  int unsigned      best_dist;
  int unsigned      cand_dist;

  // Synchroniser chain for the raw button pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= btnIn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  assign sync    = sync_q[SYNC_STAGES-1];
  assign pending = sync ^ clean_q;

  // Round-robin grant: pending index with the smallest forward distance from rr_ptr.
  always_comb begin
    grant_idx = '0;
    rr_int    = 32'(rr_ptr_q);
    best_dist = N_BTN;
    cand_dist = 0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      cand_dist = (i >= rr_int) ? (i - rr_int) : (i + N_BTN - rr_int);
      if (pending[i] && (cand_dist < best_dist)) begin
        best_dist = cand_dist;
        grant_idx = IDX_W'(i);
      end
    end
  end

  // Select the owning button's request and level; explicit compare avoids a wide bit-select.
  always_comb begin
    act_pending = 1'b0;
    act_sync    = 1'b0;
    for (int unsigned i = 0; i < N_BTN; i++) begin
      if (active_q == IDX_W'(i)) begin
        act_pending = pending[i];
        act_sync    = sync[i];
      end
    end
  end

  // Mod-N_BTN successor of the active index, not a power-of-two wrap.
  assign next_idx = (active_q == IDX_W'(N_BTN - 1)) ? '0 : active_q + IDX_W'(1);

  // Scheduler next-state: grant, time, commit or abort.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    rr_ptr_d  = rr_ptr_q;
    clean_d   = clean_q;
    press_d   = '0;
    release_d = '0;
    case (state_q)
      StIdle: begin
        if (|pending) begin
          active_d = grant_idx;
          state_d  = StTiming;
        end
      end
      StTiming: begin
        // A bounce back to the clean level wins over a simultaneous timer expiry.
        if (!act_pending) begin
          rr_ptr_d = next_idx;
          state_d  = StIdle;
        end else if (timerOut) begin
          for (int unsigned i = 0; i < N_BTN; i++) begin
            if (active_q == IDX_W'(i)) begin
              clean_d[i]   = act_sync;
              press_d[i]   = act_sync;
              release_d[i] = ~act_sync;
            end
          end
          rr_ptr_d = next_idx;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Scheduler state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      active_q  <= '0;
      rr_ptr_q  <= '0;
      clean_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      rr_ptr_q  <= rr_ptr_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Timer runs only while timing; leaving TIMING clears it for the next grant.
  assign timerControl = (state_q == StTiming);
  assign busy         = (state_q != StIdle);
  assign activeIdx    = active_q;
  assign btnClean     = clean_q;
  assign btnPress     = press_q;
  assign btnRelease   = release_q;

endmodule
